uart_axil_responder: RTL and testbench

AXI4-Lite responder terminating the chipset UART register port (13-bit address, 32-bit data) and driving a serial 8N1 transmit line. Register writes push bytes into a TX FIFO. A baud-rate serializer drains the FIFO. A level interrupt signals that the transmitter has gone idle. The block sits in the chipset clock domain, directly opposite the system's UART AXI-Lite initiator port.

---
 rtl/uart_axil_pkg.sv | 34 +++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_axil_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_axil_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axil_pkg.sv
// Shared definitions for the UART AXI-Lite responder: register map, responses, CTRL bits, serializer states.
// Optional parity support is selected with UART_TX_PARITY_EN.
package uart_axil_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_PAR_EN  = 2;
    localparam int CTRL_PAR_ODD = 3;

`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
    localparam logic [3:0] CTRL_WMASK = 4'h3;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,S_PARITY = 3'd4
`endif
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO for the UART transmitter; pointers carry an extra wrap bit.
// A push while full is dropped; full is judged before any same-cycle pop.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [7:0]                    i_data,
    input  logic                          i_pop,
    output logic [7:0]                    o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_axil_responder.sv
// AXI4-Lite register port feeding a TX FIFO and an 8N1 serializer with idle interrupt.
// Define UART_TX_PARITY_EN to add a configurable parity bit after the data bits.
//
// state    | meaning
// S_IDLE   | waiting for tx_en && fifo not empty; pops byte and samples divisor
// S_START  | start bit (0)
// S_DATA   | 8 data bits, LSB first
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (1), then back to idle
module uart_axil_responder
    import uart_axil_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        chipset_clk,
    input  logic        rst_n,
    input  logic [12:0] uart_axi_awaddr,
    input  logic        uart_axi_awvalid,
    output logic        uart_axi_awready,
    input  logic [31:0] uart_axi_wdata,
    input  logic [3:0]  uart_axi_wstrb,
    input  logic        uart_axi_wvalid,
    output logic        uart_axi_wready,
    output logic [1:0]  uart_axi_bresp,
    output logic        uart_axi_bvalid,
    input  logic        uart_axi_bready,
    input  logic [12:0] uart_axi_araddr,
    input  logic        uart_axi_arvalid,
    output logic        uart_axi_arready,
    output logic [31:0] uart_axi_rdata,
    output logic [1:0]  uart_axi_rresp,
    output logic        uart_axi_rvalid,
    input  logic        uart_axi_rready,
    output logic        uart_tx,
    output logic        uart_irq
);

    localparam int LW = $clog2(FIFO_DEPTH);

    logic        r_aw_held;
    logic [1:0]  r_aw_reg;
    logic        r_w_held;
    logic [15:0] r_wdata;
    logic [1:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [3:0]  r_ctrl;
    logic [15:0] r_div;

    tx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_div_lat;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_irq;
`ifdef UART_TX_PARITY_EN
    logic        r_par_on;
    logic        r_par;
`endif

    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_do_write;
    logic [1:0]  w_wr_reg;
    logic [15:0] w_wr_data;
    logic [1:0]  w_wr_strb;
    logic        w_push;
    logic        w_pop;
    logic        w_busy;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_fifo_data;
    logic [LW:0] w_level;
    logic [8:0]  w_level9;
    logic [31:0] w_status;
    logic [31:0] w_rd_mux;
    logic        w_unused_ok;

    assign uart_axi_awready = !r_aw_held && !r_bvalid;
    assign uart_axi_wready  = !r_w_held && !r_bvalid;
    assign uart_axi_arready = !r_rvalid;
    assign uart_axi_bvalid  = r_bvalid;
    assign uart_axi_bresp   = r_bresp;
    assign uart_axi_rvalid  = r_rvalid;
    assign uart_axi_rdata   = r_rdata;
    assign uart_axi_rresp   = RESP_OKAY;
    assign uart_tx          = r_tx;
    assign uart_irq         = r_irq;

    assign w_aw_fire  = uart_axi_awvalid && uart_axi_awready;
    assign w_w_fire   = uart_axi_wvalid && uart_axi_wready;
    // The write fires in the cycle the later channel handshakes, so bvalid follows one cycle later.
    assign w_do_write = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    assign w_wr_reg   = r_aw_held ? r_aw_reg : uart_axi_awaddr[3:2];
    assign w_wr_data  = r_w_held ? r_wdata : uart_axi_wdata[15:0];
    assign w_wr_strb  = r_w_held ? r_wstrb : uart_axi_wstrb[1:0];
    assign w_push     = w_do_write && (w_wr_reg == REG_TXDATA) && w_wr_strb[0];
    assign w_busy     = (r_state != S_IDLE);
    assign w_pop      = !w_busy && r_ctrl[CTRL_TX_EN] && !w_empty;
    assign w_level9   = 9'(w_level);
    assign w_status   = {16'h0000, w_level9[7:0], 5'b00000, w_busy, w_empty, w_full};

    assign w_unused_ok = &{1'b0, uart_axi_awaddr[12:4], uart_axi_awaddr[1:0],
                           uart_axi_araddr[12:4], uart_axi_araddr[1:0],
                           uart_axi_wdata[31:16], uart_axi_wstrb[3:2], w_level9[8]};

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (chipset_clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_data  (w_wr_data[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_rd_mux = '0;
        case (uart_axi_araddr[3:2])
            REG_STATUS:  w_rd_mux = w_status;
            REG_CTRL:    w_rd_mux = {28'h0, r_ctrl};
            REG_BAUDDIV: w_rd_mux = {16'h0, r_div};
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge chipset_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_aw_reg  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_ctrl    <= '0;
            r_div     <= DEFAULT_DIV;
        end else begin
            if (r_bvalid && uart_axi_bready) r_bvalid <= 1'b0;
            if (w_do_write) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_push && w_full) ? RESP_SLVERR : RESP_OKAY;
                case (w_wr_reg)
                    REG_CTRL: begin
                        if (w_wr_strb[0]) r_ctrl <= w_wr_data[3:0] & CTRL_WMASK;
                    end
                    REG_BAUDDIV: begin
                        if (w_wr_strb[0]) r_div[7:0]  <= w_wr_data[7:0];
                        if (w_wr_strb[1]) r_div[15:8] <= w_wr_data[15:8];
                    end
                    default: ;
                endcase
            end else begin
                if (w_aw_fire) begin
                    r_aw_held <= 1'b1;
                    r_aw_reg  <= uart_axi_awaddr[3:2];
                end
                if (w_w_fire) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= uart_axi_wdata[15:0];
                    r_wstrb  <= uart_axi_wstrb[1:0];
                end
            end
        end
    end

    always_ff @(posedge chipset_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (uart_axi_arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
        end else if (r_rvalid && uart_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Line and interrupt are registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge chipset_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_lat <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_irq     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_on  <= 1'b0;
            r_par     <= 1'b0;
`endif
        end else begin
            r_irq <= r_ctrl[CTRL_IRQ_EN] && w_empty && !w_busy;
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY: r_tx <= r_par;
`endif
                default: r_tx <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state   <= S_START;
                        r_shift   <= w_fifo_data;
                        r_cnt     <= r_div;
                        r_div_lat <= r_div;
                        r_bit     <= '0;
`ifdef UART_TX_PARITY_EN
                        r_par_on  <= r_ctrl[CTRL_PAR_EN];
                        r_par     <= (^w_fifo_data) ^ r_ctrl[CTRL_PAR_ODD];
`endif
                    end
                end
                S_START: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= S_DATA;
                        r_cnt   <= r_div_lat;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt <= r_div_lat;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= r_par_on ? S_PARITY : S_STOP;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= S_STOP;
                        r_cnt   <= r_div_lat;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == 16'd0) r_state <= S_IDLE;
                    else                r_cnt   <= r_cnt - 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axil_responder.sv
// Directed plus randomized bench for uart_axil_responder against a queue-based model of the register map.
module tb_uart_axil_responder;

    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] CMASK = 4'hF;
`else
    localparam logic [3:0] CMASK = 4'h3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [12:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        tx;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  q[$];
    logic [3:0]  m_ctrl;
    logic [15:0] m_div;

    always #5 clk = ~clk;

    uart_axil_responder #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd867)) dut (
        .chipset_clk      (clk),
        .rst_n            (rst_n),
        .uart_axi_awaddr  (awaddr),
        .uart_axi_awvalid (awvalid),
        .uart_axi_awready (awready),
        .uart_axi_wdata   (wdata),
        .uart_axi_wstrb   (wstrb),
        .uart_axi_wvalid  (wvalid),
        .uart_axi_wready  (wready),
        .uart_axi_bresp   (bresp),
        .uart_axi_bvalid  (bvalid),
        .uart_axi_bready  (bready),
        .uart_axi_araddr  (araddr),
        .uart_axi_arvalid (arvalid),
        .uart_axi_arready (arready),
        .uart_axi_rdata   (rdata),
        .uart_axi_rresp   (rresp),
        .uart_axi_rvalid  (rvalid),
        .uart_axi_rready  (rready),
        .uart_tx          (tx),
        .uart_irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        s[15:8] = 8'(q.size());
        s[1] = (q.size() == 0);
        s[0] = (q.size() == DEPTH);
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [12:0] a);
        case (a[3:2])
            2'd1:    return model_status();
            2'd2:    return {28'h0, m_ctrl};
            2'd3:    return {16'h0, m_div};
            default: return 32'h0;
        endcase
    endfunction

    // Model of a write while the serializer is not consuming the FIFO.
    function automatic logic [1:0] model_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        r = 2'b00;
        case (a[3:2])
            2'd0: if (s[0]) begin
                if (q.size() >= DEPTH) r = 2'b10;
                else q.push_back(d[7:0]);
            end
            2'd2: if (s[0]) m_ctrl = d[3:0] & CMASK;
            2'd3: begin
                if (s[0]) m_div[7:0]  = d[7:0];
                if (s[1]) m_div[15:8] = d[15:8];
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int t;
        aw_done = 0; w_done = 0; t = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && t < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(negedge clk);
            t++;
            if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
            if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        chk("wr_handshake", {31'h0, aw_done && w_done}, 32'h1);
        chk("b_latency", {31'h0, bvalid}, 32'h1);
        resp = bresp;
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] resp, exp;
        exp = model_write(a, d, s);
        axi_write(a, d, s, resp);
        chk("bresp", {30'h0, resp}, {30'h0, exp});
    endtask

    task automatic axi_read(input logic [12:0] a, output logic [31:0] d);
        bit done;
        int t;
        done = 0; t = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!done && t < 20) begin
            done = arready;
            @(negedge clk);
            t++;
        end
        arvalid = 1'b0;
        chk("rd_handshake", {31'h0, done}, 32'h1);
        chk("r_latency", {31'h0, rvalid}, 32'h1);
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [12:0] a);
        logic [31:0] d;
        axi_read(a, d);
        chk(tag, d, model_read(a));
    endtask

    task automatic wait_start(input int max_cyc);
        int t;
        t = 0;
        while (tx !== 1'b0 && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        chk("start_found", {31'h0, tx === 1'b0}, 32'h1);
    endtask

    // Entered on the first cycle of the start bit; leaves on the last cycle of the stop bit.
    task automatic check_frame(input logic [7:0] b, input int div);
        logic expbit;
        bit   ok;
        for (int k = 0; k < 10; k++) begin
            expbit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            ok = 1;
            for (int c = 0; c <= div; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (tx !== expbit) ok = 0;
            end
            chk($sformatf("frame_%02h_bit%0d", b, k), {31'h0, ok}, 32'h1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, v, old_div, new_div;
        logic [3:0]  s;
        int          div, n;
        bit          ok;

        rst_n = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1'b1;
        araddr = '0; arvalid = 0; rready = 1'b1;
        m_ctrl = 4'h0; m_div = 16'd867;
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'h0, awready}, 32'h1);
        chk("rst_wready",  {31'h0, wready},  32'h1);
        chk("rst_arready", {31'h0, arready}, 32'h1);
        chk("rst_bvalid",  {31'h0, bvalid},  32'h0);
        chk("rst_rvalid",  {31'h0, rvalid},  32'h0);
        chk("rst_bresp",   {30'h0, bresp},   32'h0);
        chk("rst_rresp",   {30'h0, rresp},   32'h0);
        chk("rst_rdata",   rdata,            32'h0);
        chk("rst_tx",      {31'h0, tx},      32'h1);
        chk("rst_irq",     {31'h0, irq},     32'h0);
        rst_n = 1'b1;

        axi_read(13'h004, d);
        chk("status_after_reset", d, 32'h0000_0002);
        chk("rresp", {30'h0, rresp}, 32'h0);
        rd_chk("ctrl_reset", 13'h008);
        rd_chk("div_reset", 13'h00C);
        rd_chk("txdata_reads0", 13'h000);

        // 0xA5 frame with exact start timing.
        wr(13'h00C, 32'd3, 4'hF);
        wr(13'h008, 32'h1, 4'h1);
        wr(13'h000, 32'hA5, 4'h1);
        @(negedge clk);
        chk("a5_tx_before_start", {31'h0, tx}, 32'h1);
        @(negedge clk);
        chk("a5_start_at_bvalid_plus2", {31'h0, tx}, 32'h0);
        check_frame(q.pop_front(), 3);
        @(negedge clk);
        chk("a5_idle_after", {31'h0, tx}, 32'h1);

        // Randomized rounds: config readback, queued bytes, back-to-back frames.
        for (int r = 0; r < 3; r++) begin
            wr(13'h008, $urandom & 32'hFFFF_FFFE, 4'($urandom_range(0, 15)));
            rd_chk("ctrl_rand_rb", 13'h008);
            wr(13'h00C, $urandom, 4'($urandom_range(0, 15)));
            rd_chk("div_rand_rb", 13'h00C);
            div = $urandom_range(1, 4);
            wr(13'h00C, 32'(div), 4'h3);
            wr(13'h008, 32'h0, 4'h1);
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                s = 4'($urandom_range(0, 15));
                if (i == 0) s[0] = 1'b1;
                wr(13'h000, $urandom, s);
            end
            rd_chk("status_queued", 13'h004);
            chk("irq_disabled", {31'h0, irq}, 32'h0);
            wr(13'h00C | 13'($urandom_range(0, 1) << 12), 32'(div), 4'h3);
            wr(13'h008, 32'h1, 4'h1);
            while (q.size() > 0) begin
                wait_start(4 * (div + 1) + 8);
                check_frame(q.pop_front(), div);
            end
            rd_chk("status_drained", 13'h004);
        end

        // FIFO overflow with transmitter disabled.
        wr(13'h00C, 32'd1, 4'h3);
        wr(13'h008, 32'h0, 4'h1);
        for (int i = 0; i < DEPTH + 1; i++) wr(13'h000, $urandom, 4'h1);
        chk("overflow_bresp", {30'h0, bresp}, 32'h2);
        axi_read(13'h004, d);
        chk("status_full", d, 32'h0000_1001);

        // AW three cycles ahead of W, enabling tx and irq.
        @(negedge clk);
        awaddr = 13'h008; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("aw_early_awready_low", {31'h0, awready}, 32'h0);
        chk("aw_early_no_bvalid", {31'h0, bvalid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("aw_early_wready", {31'h0, wready}, 32'h1);
        wdata = 32'h3; wstrb = 4'h1; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("aw_early_bvalid", {31'h0, bvalid}, 32'h1);
        chk("aw_early_bresp", {30'h0, bresp}, 32'h0);
        m_ctrl = 4'h3;
        while (q.size() > 0) begin
            wait_start(60);
            chk("irq_low_while_busy", {31'h0, irq}, 32'h0);
            check_frame(q.pop_front(), 1);
        end
        chk("irq_low_last_stop", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'h0, irq}, 32'h1);

        // Read held by rready=0 while a write to the same register completes.
        old_div = {16'h0, m_div};
        new_div = {16'h0, 16'($urandom_range(2, 16'hFFFE))};
        @(negedge clk);
        araddr = 13'h00C; arvalid = 1'b1; rready = 1'b0;
        awaddr = 13'h00C; wdata = new_div; wstrb = 4'h3; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("hold_bvalid", {31'h0, bvalid}, 32'h1);
        chk("hold_bresp", {30'h0, bresp}, 32'h0);
        m_div = new_div[15:0];
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || rdata !== old_div || arready !== 1'b0) ok = 0;
            @(negedge clk);
        end
        chk("hold_stable", {31'h0, ok}, 32'h1);
        chk("hold_rdata_old", rdata, old_div);
        rready = 1'b1;
        @(negedge clk);
        chk("hold_rvalid_clear", {31'h0, rvalid}, 32'h0);
        rd_chk("div_after_hold", 13'h00C);

        // Asynchronous reset during data bits.
        wr(13'h00C, 32'd3, 4'h3);
        wr(13'h000, 32'h00, 4'h1);
        wait_start(20);
        repeat (8) @(negedge clk);
        chk("pre_reset_tx_low", {31'h0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("reset_tx_high", {31'h0, tx}, 32'h1);
        chk("reset_irq_low", {31'h0, irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ctrl = 4'h0;
        m_div = 16'd867;
        axi_read(13'h004, d);
        chk("status_after_midframe_reset", d, 32'h0000_0002);
        rd_chk("ctrl_after_reset", 13'h008);
        rd_chk("div_after_reset", 13'h00C);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 0;
        end
        chk("tx_quiet_after_reset", {31'h0, ok}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
